multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ALUOP_W, default 3, giving the aluOp width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum wait cycles for mem_ready before error.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port opcode  in  6  instruction bits [31:26], valid from DECODE onward.
REQ-006 SHALL have port funcCode  in  6  instruction bits [5:0].
REQ-007 SHALL have port mem_ready  in  1  memory completion strobe for the current fetch or data access.
REQ-008 SHALL have port pc_write  out  1  PC update enable.
REQ-009 SHALL have port ir_write  out  1  instruction register load.
REQ-010 SHALL have ports regDst, jump, jal, jumpRegister, branch, memRead, memToReg, memWrite, aluSrc and regWrite, each  out  1, with the existing datapath meanings.
REQ-011 SHALL have port aluOp  out  ALUOP_W  ALU operation code.
REQ-012 SHALL have ports syscall, halted and mem_err, each  out  1: syscall is a one-cycle decode pulse; halted and mem_err are sticky status.
REQ-013 SHALL have port state  out  3  current FSM state, for debug.

Function
REQ-014 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5 and ERR=6.
REQ-015 FETCH SHALL assert memRead and stay in FETCH until mem_ready; in the mem_ready cycle it SHALL assert ir_write and pc_write (PC+4) and go to DECODE.
REQ-016 DECODE SHALL last one cycle and assert no write enables.
REQ-017 From DECODE, syscall (opcode 0, funct 0x0C) SHALL pulse syscall and go to HALT; every other instruction SHALL go to EXEC.
REQ-018 EXEC SHALL drive aluOp and aluSrc from the decode table.
REQ-019 aluOp decode SHALL be: AND gives ALU_AND; OR/ORI give ALU_OR; ADD/ADDI/ADDIU/LW/SW give ALU_add; SUB/BEQ/BNE give ALU_sub; LUI gives 3; everything else gives ALU_slt. Codes are zero-extended to ALUOP_W.
REQ-020 Out of EXEC: LW/SW go to MEM; BEQ/BNE assert branch and go to FETCH; J/JAL/JR assert jump and pc_write and go to FETCH, with JAL also asserting jal and JR also asserting jumpRegister; all other instructions go to WB.
REQ-021 MEM SHALL hold memRead (LW) or memWrite (SW) until mem_ready; then LW goes to WB and SW goes to FETCH.
REQ-022 WB SHALL assert regWrite for exactly one cycle and go to FETCH; regDst is 1 for R-type; memToReg is 1 for LW.
REQ-023 JAL write-back of r31 SHALL occur in the EXEC cycle, with regWrite=1 and jal=1.
REQ-024 All control outputs SHALL be 0 outside the states named above (Moore outputs, registered decode).
REQ-025 A wait counter SHALL clear on entry to FETCH or MEM and count the cycles without mem_ready.
REQ-026 When the wait counter reaches MEM_TIMEOUT, the FSM SHALL go to ERR; mem_ready in that same cycle wins.
REQ-027 HALT and ERR SHALL be absorbing until rst; halted=1 in HALT, mem_err=1 in ERR.
REQ-028 mem_ready outside FETCH and MEM SHALL be ignored.

Reset
REQ-029 While rst=1 at a clock edge, the state SHALL become FETCH, the wait counter 0, and all outputs 0, including halted and mem_err.
REQ-030 Reset mid-MEM SHALL abandon the access: memWrite is 0 in the cycle after reset, and no regWrite follows.
REQ-031 The first FETCH memRead SHALL appear in the cycle after rst deasserts.

Structure
REQ-032 The shared package mips_ctrl_pkg SHALL hold the state encodings, the opcode and funct constants, and the ALU_* codes.
REQ-033 A combinational sub-module instr_decode SHALL map opcode/funcCode to static class bits and aluOp; the FSM gates those bits by state.
REQ-034 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-035 ADD (op 0x00, funct 0x20) with mem_ready=1 throughout -> states 0,1,2,4,0; regWrite=1 only in WB; regDst=1; aluOp=ALU_add.
REQ-036 LW (op 0x23) with mem_ready low for 3 cycles in MEM -> memRead held 4 MEM cycles; then WB with memToReg=1 and regWrite=1.
REQ-037 SW (op 0x2B) then BEQ (op 0x04) -> SW: memWrite in MEM, no WB. BEQ: branch=1 and aluOp=ALU_sub in EXEC, then FETCH.
REQ-038 Syscall (op 0, funct 0x0C) -> syscall=1 for one cycle in DECODE; halted=1 from the next cycle; no further ir_write until rst.
REQ-039 mem_ready held 0 in FETCH -> state=ERR after MEM_TIMEOUT (255) wait cycles, with mem_err=1. A second run with mem_ready=1 exactly at cycle 255 -> DECODE, no error.
REQ-040 rst asserted during MEM of SW -> next cycle state=FETCH, memWrite=0, halted=0, mem_err=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state encodings, opcode/funct constants and ALU codes shared by the multicycle controller.
package mips_ctrl_pkg;
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                           S_WB = 3'd4, S_HALT = 3'd5, S_ERR = 3'd6;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0d,
                           OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0c, FN_ADD = 6'h20, FN_SUB = 6'h22,
                           FN_AND = 6'h24, FN_OR = 6'h25;
    localparam logic [2:0] ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2, ALU_LUI = 3'd3,
                           ALU_SUB = 3'd6, ALU_SLT = 3'd7;
    typedef struct packed {
        logic rtype;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic jal;
        logic jr;
        logic alu_src;
    } ctrl_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: maps opcode/funct to static instruction class bits and the ALU operation.
module instr_decode
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funcCode,
    output ctrl_t              ctrl,
    output logic               syscall,
    output logic [ALUOP_W-1:0] alu_op
);
    logic rtype, is_lw, is_sw, is_br, is_jal, is_jr, is_addi;
    logic [2:0] code;
    assign rtype   = opcode == OP_RTYPE;
    assign is_lw   = opcode == OP_LW;
    assign is_sw   = opcode == OP_SW;
    assign is_br   = opcode == OP_BEQ || opcode == OP_BNE;
    assign is_jal  = opcode == OP_JAL;
    assign is_jr   = rtype && funcCode == FN_JR;
    assign is_addi = opcode == OP_ADDI || opcode == OP_ADDIU;
    assign syscall = rtype && funcCode == FN_SYSCALL;
    assign ctrl = '{
        rtype:   rtype,
        load:    is_lw,
        store:   is_sw,
        branch:  is_br,
        jump:    opcode == OP_J || is_jal || is_jr,
        jal:     is_jal,
        jr:      is_jr,
        alu_src: is_addi || is_lw || is_sw || opcode == OP_ORI || opcode == OP_LUI
    };
    assign code = rtype ? (funcCode == FN_AND ? ALU_AND :
                           funcCode == FN_OR  ? ALU_OR  :
                           funcCode == FN_ADD ? ALU_ADD :
                           funcCode == FN_SUB ? ALU_SUB : ALU_SLT) :
                  opcode == OP_ORI                ? ALU_OR  :
                  (is_addi || is_lw || is_sw)     ? ALU_ADD :
                  is_br                           ? ALU_SUB :
                  opcode == OP_LUI                ? ALU_LUI : ALU_SLT;
    assign alu_op = ALUOP_W'(code);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with memory-wait timeout and sticky halt/error status.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funcCode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               regDst,
    output logic               jump,
    output logic               jal,
    output logic               jumpRegister,
    output logic               branch,
    output logic               memRead,
    output logic               memToReg,
    output logic               memWrite,
    output logic               aluSrc,
    output logic               regWrite,
    output logic [ALUOP_W-1:0] aluOp,
    output logic               syscall,
    output logic               halted,
    output logic               mem_err,
    output logic [2:0]         state
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    ctrl_t dec, dq;
    logic [ALUOP_W-1:0] dec_alu, alu_q;
    logic dec_sys, live, timeout, waiting;
    logic f, d, e, m, w;
    logic [2:0] nxt;
    logic [CW-1:0] wait_cnt;
    instr_decode #(.ALUOP_W(ALUOP_W)) u_dec (
        .opcode  (opcode),
        .funcCode(funcCode),
        .ctrl    (dec),
        .syscall (dec_sys),
        .alu_op  (dec_alu)
    );
    assign timeout = wait_cnt == CW'(MEM_TIMEOUT);
    assign waiting = live && (state == S_FETCH || state == S_MEM) && nxt == state;
    always_comb begin
        nxt = state;
        if (live)
            case (state)
                S_FETCH:  nxt = mem_ready ? S_DECODE : timeout ? S_ERR : S_FETCH;
                S_DECODE: nxt = dec_sys ? S_HALT : S_EXEC;
                S_EXEC:   nxt = (dq.load || dq.store) ? S_MEM : (dq.branch || dq.jump) ? S_FETCH : S_WB;
                S_MEM:    nxt = !mem_ready ? (timeout ? S_ERR : S_MEM) : dq.load ? S_WB : S_FETCH;
                S_WB:     nxt = S_FETCH;
                S_HALT:   nxt = S_HALT;
                S_ERR:    nxt = S_ERR;
                default:  nxt = S_FETCH;
            endcase
    end
    // live stays low for the reset-release cycle so every output is 0 until the FSM actually runs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            live     <= 1'b0;
            wait_cnt <= '0;
            dq       <= '0;
            alu_q    <= '0;
        end else begin
            live     <= 1'b1;
            state    <= nxt;
            wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
            if (d) begin
                dq    <= dec;
                alu_q <= dec_alu;
            end
        end
    end
    assign f = live && state == S_FETCH;
    assign d = live && state == S_DECODE;
    assign e = live && state == S_EXEC;
    assign m = live && state == S_MEM;
    assign w = live && state == S_WB;
    assign memRead      = f || (m && dq.load);
    assign memWrite     = m && dq.store;
    assign ir_write     = f && mem_ready;
    assign pc_write     = (f && mem_ready) || (e && dq.jump);
    assign jump         = e && dq.jump;
    assign jal          = e && dq.jal;
    assign jumpRegister = e && dq.jr;
    assign branch       = e && dq.branch;
    assign aluSrc       = e && dq.alu_src;
    assign aluOp        = e ? alu_q : '0;
    assign regWrite     = w || (e && dq.jal);
    assign regDst       = w && dq.rtype;
    assign memToReg     = w && dq.load;
    assign syscall      = d && dec_sys;
    assign halted       = live && state == S_HALT;
    assign mem_err      = live && state == S_ERR;
endmodule
